// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// multi-cycle sequencer states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_sequencer.sv
// Multi-cycle execute sequencer: holds a mul/div-class op in E for MC_LAT
// cycles, stalling the front of the pipe for MC_LAT-1 of them.
module mc_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mc_start_e,
  output logic mc_stall,
  output logic mc_busy,
  output logic mc_done
);

  // cnt keeps at least one bit so MC_LAT=1 still elaborates cleanly
  localparam int unsigned CNT_BITS = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'((MC_LAT > 1) ? MC_LAT - 2 : 0);

  mc_state_t           state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_stall  = 1'b0;
    mc_done   = 1'b0;
    case (state)
      IDLE: begin
        if (mc_start_e) begin
          if (MC_LAT > 1) begin
            mc_stall  = 1'b1;
            cnt_nxt   = CNT_LOAD;
            state_nxt = BUSY;
          end else begin
            mc_done = 1'b1;
          end
        end
      end
      BUSY: begin
        // mc_start_e is ignored here: it still reflects the op held in E
        if (cnt != '0) begin
          mc_stall = 1'b1;
          cnt_nxt  = cnt - CNT_BITS'(1);
        end else begin
          mc_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mc_busy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: forwarding, load-use
// stall, branch flush, multi-cycle execute stall and performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              reg_write_e,
  input  logic              is_load_e,
  input  logic              mc_start_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  input  logic              take_branch_e,
  input  logic              perf_clr,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic     m_fwd, w_fwd;
  fwd_sel_t fwd_a, fwd_b;
  logic     load_use;
  logic     mc_stall;

  assign m_fwd = reg_write_m && (rd_m != '0);
  assign w_fwd = reg_write_w && (rd_w != '0);

  always_comb begin
    fwd_a = FWD_RF;
    if (m_fwd && (rd_m == rs1_e))      fwd_a = FWD_M;
    else if (w_fwd && (rd_w == rs1_e)) fwd_a = FWD_W;
    fwd_b = FWD_RF;
    if (m_fwd && (rd_m == rs2_e))      fwd_b = FWD_M;
    else if (w_fwd && (rd_w == rs2_e)) fwd_b = FWD_W;
  end

  assign forward_a_e = fwd_a;
  assign forward_b_e = fwd_b;

  assign load_use = is_load_e && reg_write_e && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  mc_sequencer #(
    .MC_LAT(MC_LAT)
  ) u_mc_seq (
    .clk       (clk),
    .rst       (rst),
    .mc_start_e(mc_start_e),
    .mc_stall  (mc_stall),
    .mc_busy   (mc_busy),
    .mc_done   (mc_done)
  );

  // branch flush wins, then the multi-cycle hold, then load-use
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (take_branch_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (mc_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (perf_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_f && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (take_branch_e && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: default build, MC_LAT=1 build
// and CNT_W=4 build driven from shared stimulus.
module tb_hazard_ctrl;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          reg_write_e, is_load_e, mc_start_e, reg_write_m, reg_write_w;
  logic          take_branch_e, perf_clr;

  logic [1:0]  fa, fb, fa1, fb1, fa4, fb4;
  logic        sf, sd, se, fd, fe, fm, busy, done;
  logic        sf1, sd1, se1, fd1, fe1, fm1, busy1, done1;
  logic        sf4, sd4, se4, fd4, fe4, fm4, busy4, done4;
  logic [31:0] sc, fc, sc1, fc1;
  logic [3:0]  sc4, fc4;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .MC_LAT(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .is_load_e(is_load_e), .mc_start_e(mc_start_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .take_branch_e(take_branch_e), .perf_clr(perf_clr),
    .forward_a_e(fa), .forward_b_e(fb), .stall_f(sf), .stall_d(sd), .stall_e(se),
    .flush_d(fd), .flush_e(fe), .flush_m(fm), .mc_busy(busy), .mc_done(done),
    .stall_count(sc), .flush_count(fc)
  );

  hazard_ctrl #(.REG_AW(AW), .MC_LAT(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .is_load_e(is_load_e), .mc_start_e(mc_start_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .take_branch_e(take_branch_e), .perf_clr(perf_clr),
    .forward_a_e(fa1), .forward_b_e(fb1), .stall_f(sf1), .stall_d(sd1), .stall_e(se1),
    .flush_d(fd1), .flush_e(fe1), .flush_m(fm1), .mc_busy(busy1), .mc_done(done1),
    .stall_count(sc1), .flush_count(fc1)
  );

  hazard_ctrl #(.REG_AW(AW), .MC_LAT(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .is_load_e(is_load_e), .mc_start_e(mc_start_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .take_branch_e(take_branch_e), .perf_clr(perf_clr),
    .forward_a_e(fa4), .forward_b_e(fb4), .stall_f(sf4), .stall_d(sd4), .stall_e(se4),
    .flush_d(fd4), .flush_e(fe4), .flush_m(fm4), .mc_busy(busy4), .mc_done(done4),
    .stall_count(sc4), .flush_count(fc4)
  );

  typedef enum int {
    S_FA, S_FB, S_SF, S_SD, S_SE, S_FD, S_FE, S_FM, S_BUSY, S_DONE, S_SC, S_FC,
    S1_SF, S1_DONE, S1_BUSY, S1_SC, S4_SC, S4_FC
  } sig_id_t;

  typedef struct {
    string       tag;
    sig_id_t     id;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] observe(input sig_id_t id);
    case (id)
      S_FA:    return {30'd0, fa};
      S_FB:    return {30'd0, fb};
      S_SF:    return {31'd0, sf};
      S_SD:    return {31'd0, sd};
      S_SE:    return {31'd0, se};
      S_FD:    return {31'd0, fd};
      S_FE:    return {31'd0, fe};
      S_FM:    return {31'd0, fm};
      S_BUSY:  return {31'd0, busy};
      S_DONE:  return {31'd0, done};
      S_SC:    return sc;
      S_FC:    return fc;
      S1_SF:   return {31'd0, sf1};
      S1_DONE: return {31'd0, done1};
      S1_BUSY: return {31'd0, busy1};
      S1_SC:   return sc1;
      S4_SC:   return {28'd0, sc4};
      S4_FC:   return {28'd0, fc4};
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input sig_id_t id, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.id  = id;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic drain();
    exp_t        item;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      item = sb.pop_front();
      obs  = observe(item.id);
      checks++;
      assert (obs === item.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_e = 1'b0; is_load_e = 1'b0; mc_start_e = 1'b0;
    reg_write_m = 1'b0; reg_write_w = 1'b0; take_branch_e = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic load_use_on(input logic [AW-1:0] rd);
    is_load_e = 1'b1; reg_write_e = 1'b1; rd_e = rd; rs2_d = 5'd7;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    quiet();
    #3;
    push("rst_sf", S_SF, 0); push("rst_busy", S_BUSY, 0); push("rst_done", S_DONE, 0);
    push("rst_sc", S_SC, 0); push("rst_fc", S_FC, 0); push("rst_fa", S_FA, 0);
    push("rst_fd", S_FD, 0);
    drain();
    next();
    rst = 1'b0;

    // forwarding
    rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1; rs2_e = 5'd3;
    #1; push("fwd_m_pri", S_FA, 2); push("fwd_b_none", S_FB, 0); drain();
    rd_m = 5'd0;
    #1; push("fwd_w", S_FA, 1); drain();
    rs2_e = 5'd9; rd_m = 5'd9; reg_write_m = 1'b0; rd_w = 5'd9;
    #1; push("fwd_m_nowrite", S_FB, 1); drain();
    rs1_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0; reg_write_m = 1'b1;
    #1; push("fwd_x0", S_FA, 0); drain();
    quiet();

    // load-use
    next();
    load_use_on(5'd7);
    #3;
    push("lu_sf", S_SF, 1); push("lu_sd", S_SD, 1); push("lu_fe", S_FE, 1);
    push("lu_se", S_SE, 0); push("lu_sc_before", S_SC, 0);
    drain();
    next();
    quiet();
    load_use_on(5'd0);
    rs2_d = 5'd0;
    #3; push("lu_x0_sf", S_SF, 0); push("lu_sc", S_SC, 1); drain();

    // branch together with a load-use match
    next();
    quiet();
    take_branch_e = 1'b1;
    load_use_on(5'd7);
    #3;
    push("br_fd", S_FD, 1); push("br_fe", S_FE, 1); push("br_sf", S_SF, 0); push("br_sd", S_SD, 0);
    drain();
    next();
    quiet();
    #3; push("br_fc", S_FC, 1); push("br_sc", S_SC, 1); push("br_fc4", S4_FC, 1); drain();

    // multi-cycle op, MC_LAT=4 and MC_LAT=1 side by side
    next();
    mc_start_e = 1'b1;
    #3;
    push("mc1_sf", S_SF, 1); push("mc1_se", S_SE, 1); push("mc1_fm", S_FM, 1);
    push("mc1_busy", S_BUSY, 0); push("mc1_done", S_DONE, 0);
    push("lat1_sf", S1_SF, 0); push("lat1_done", S1_DONE, 1); push("lat1_busy", S1_BUSY, 0);
    drain();
    next();
    #3; push("mc2_sf", S_SF, 1); push("mc2_busy", S_BUSY, 1); push("mc2_done", S_DONE, 0); drain();
    next();
    #3; push("mc3_sf", S_SF, 1); push("mc3_busy", S_BUSY, 1); push("mc3_done", S_DONE, 0); drain();
    next();
    #3;
    push("mc4_sf", S_SF, 0); push("mc4_se", S_SE, 0); push("mc4_busy", S_BUSY, 1);
    push("mc4_done", S_DONE, 1);
    drain();
    next();
    mc_start_e = 1'b0;
    #3;
    push("mc_after_busy", S_BUSY, 0); push("mc_after_done", S_DONE, 0);
    push("mc_sc", S_SC, 4); push("lat1_sc", S1_SC, 1); push("mc_sc4", S4_SC, 4);
    drain();

    // reset on cycle 2 of a busy op
    next();
    mc_start_e = 1'b1;
    next();
    #3; push("rb_pre_busy", S_BUSY, 1); push("rb_pre_sf", S_SF, 1); drain();
    #1;
    rst = 1'b1;
    mc_start_e = 1'b0;
    #1;
    push("rb_sf", S_SF, 0); push("rb_se", S_SE, 0); push("rb_fm", S_FM, 0);
    push("rb_busy", S_BUSY, 0); push("rb_sc", S_SC, 0); push("rb_fc", S_FC, 0);
    drain();
    next();
    rst = 1'b0;
    #3; push("rb_post_busy", S_BUSY, 0); push("rb_post_sf", S_SF, 0); drain();

    // counter saturation at CNT_W=4, then clear with a stall still active
    next();
    load_use_on(5'd7);
    repeat (20) next();
    #2;
    push("sat_sc4", S4_SC, 15); push("sat_sc", S_SC, 20); push("sat_sf", S_SF, 1);
    drain();
    perf_clr = 1'b1;
    next();
    quiet();
    #3; push("clr_sc4", S4_SC, 0); push("clr_sc", S_SC, 0); push("clr_fc", S_FC, 0); drain();
    next();
    #3; push("clr_hold_sc", S_SC, 0); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
